writeback: RTL and testbench

WRITEBACK -- requirements
Module: writeback

---
 rtl/riscv_pkg.sv | 16 +
 rtl/load_align.sv | 32 +++
 rtl/writeback.sv | 100 ++++++++++
 tb/tb_writeback.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: load funct3 encodings and writeback FSM states.
// Used by the execute and writeback stages.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_t;

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the byte/half lane and sign- or zero-extends.
// Unknown funct3 values pass the word through untouched.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = data[{offset, 3'b000} +: 8];
    h = offset[1] ? data[31:16] : data[15:0];
  end

  always_comb begin
    result = data;
    unique case (funct3)
      F3_LB:   result = {{24{b[7]}}, b};
      F3_LBU:  result = {24'h0, b};
      F3_LH:   result = {{16{h[15]}}, h};
      F3_LHU:  result = {16'h0, h};
      F3_LW:   result = data;
      default: result = data;
    endcase
  end

endmodule

// File: rtl/writeback.sv
// Writeback stage: load wait FSM, register file with same-cycle bypass,
// and a counter of committed rd writes.
module writeback
  import riscv_pkg::*;
#(
  parameter logic [31:0] REG_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_alu_to_reg,
  input  logic        wb_mem_to_reg,
  input  logic [31:0] wb_result,
  input  logic [4:0]  wb_dest_reg_sel,
  input  logic [1:0]  wb_read_address,
  input  logic [2:0]  wb_alu_operation,
  input  logic [31:0] dmem_read_data,
  input  logic        dmem_read_valid,
  input  logic        inst_fetch_stall,
  input  logic [4:0]  src1_select,
  input  logic [4:0]  src2_select,
  output logic [31:0] reg_rdata1,
  output logic [31:0] reg_rdata2,
  output logic        stall_read,
  output logic [31:0] commit_count
);

  wb_state_t   state;
  wb_state_t   state_nxt;
  logic [31:0] regs [32];
  logic [31:0] load_data;
  logic [31:0] wdata;
  logic        commit;
  logic        wr_en;

  load_align u_align (
    .data   (dmem_read_data),
    .offset (wb_read_address),
    .funct3 (wb_alu_operation),
    .result (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (wb_mem_to_reg && !dmem_read_valid)
          state_nxt = WAIT_LOAD;
      WAIT_LOAD:
        if (dmem_read_valid)
          state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall_read = (state == WAIT_LOAD) ||
                 (wb_mem_to_reg && !dmem_read_valid);
  end

  // Gating with reset keeps a stray valid during reset from committing.
  always_comb begin
    commit = wb_alu_to_reg && !inst_fetch_stall &&
             (!wb_mem_to_reg || dmem_read_valid) && !reset;
    wr_en  = commit && (wb_dest_reg_sel != 5'd0);
    wdata  = wb_mem_to_reg ? load_data : wb_result;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= (i == 0) ? 32'h0 : REG_RESET;
    end else if (wr_en) begin
      regs[wb_dest_reg_sel] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)      commit_count <= 32'h0;
    else if (wr_en) commit_count <= commit_count + 32'd1;
  end

  function automatic logic [31:0] rd_port(input logic [4:0] sel);
    unique case (1'b1)
      (sel == 5'd0):                     rd_port = 32'h0;
      (wr_en && sel == wb_dest_reg_sel): rd_port = wdata;
      default:                           rd_port = regs[sel];
    endcase
  endfunction

  always_comb begin
    reg_rdata1 = rd_port(src1_select);
    reg_rdata2 = rd_port(src2_select);
  end

endmodule

// File: tb/tb_writeback.sv
// Directed bench for writeback: ALU/load commits, bypass, stalls, reset.
// Expected values are hand-computed constants.
module tb_writeback;
  import riscv_pkg::*;

  localparam logic [31:0] RV = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_alu_to_reg, wb_mem_to_reg;
  logic [31:0] wb_result;
  logic [4:0]  wb_dest_reg_sel;
  logic [1:0]  wb_read_address;
  logic [2:0]  wb_alu_operation;
  logic [31:0] dmem_read_data;
  logic        dmem_read_valid, inst_fetch_stall;
  logic [4:0]  src1_select, src2_select;
  logic [31:0] reg_rdata1, reg_rdata2, commit_count;
  logic        stall_read;

  int n_assert = 0;
  int n_fail   = 0;

  writeback #(.REG_RESET(RV)) dut (
    .clk              (clk),
    .reset            (reset),
    .wb_alu_to_reg    (wb_alu_to_reg),
    .wb_mem_to_reg    (wb_mem_to_reg),
    .wb_result        (wb_result),
    .wb_dest_reg_sel  (wb_dest_reg_sel),
    .wb_read_address  (wb_read_address),
    .wb_alu_operation (wb_alu_operation),
    .dmem_read_data   (dmem_read_data),
    .dmem_read_valid  (dmem_read_valid),
    .inst_fetch_stall (inst_fetch_stall),
    .src1_select      (src1_select),
    .src2_select      (src2_select),
    .reg_rdata1       (reg_rdata1),
    .reg_rdata2       (reg_rdata2),
    .stall_read       (stall_read),
    .commit_count     (commit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    wb_alu_to_reg    = 1'b0;
    wb_mem_to_reg    = 1'b0;
    wb_result        = 32'h0;
    wb_dest_reg_sel  = 5'd0;
    wb_read_address  = 2'd0;
    wb_alu_operation = 3'd0;
    dmem_read_data   = 32'h0;
    dmem_read_valid  = 1'b0;
    inst_fetch_stall = 1'b0;
  endtask

  task automatic load(input logic [4:0] rd, input logic [2:0] f3,
                      input logic [1:0] off, input logic [31:0] d);
    wb_alu_to_reg    = 1'b1;
    wb_mem_to_reg    = 1'b1;
    wb_dest_reg_sel  = rd;
    wb_alu_operation = f3;
    wb_read_address  = off;
    dmem_read_data   = d;
    dmem_read_valid  = 1'b1;
    src1_select      = rd;
  endtask

  initial begin
    idle_in();
    src1_select = 5'd7;
    src2_select = 5'd0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_x7", reg_rdata1, RV);
    chk("rst_x0", reg_rdata2, 32'h0);
    chk("rst_cnt", commit_count, 32'h0);
    chk("rst_stall", {31'h0, stall_read}, 32'h0);

    // ALU write with bypass
    wb_alu_to_reg   = 1'b1;
    wb_dest_reg_sel = 5'd5;
    wb_result       = 32'h1234_5678;
    src1_select     = 5'd5;
    #1;
    chk("alu_byp", reg_rdata1, 32'h1234_5678);
    step();
    idle_in();
    #1;
    chk("alu_store", reg_rdata1, 32'h1234_5678);
    chk("alu_cnt", commit_count, 32'd1);

    // x0 write discarded
    wb_alu_to_reg   = 1'b1;
    wb_dest_reg_sel = 5'd0;
    wb_result       = 32'hFFFF_FFFF;
    src1_select     = 5'd0;
    #1;
    chk("x0_byp", reg_rdata1, 32'h0);
    step();
    idle_in();
    #1;
    chk("x0_read", reg_rdata1, 32'h0);
    chk("x0_cnt", commit_count, 32'd1);

    // LB offset 3, valid low for three cycles
    load(5'd6, F3_LB, 2'd3, 32'h80AA_BBCC);
    dmem_read_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ld_stall", {31'h0, stall_read}, 32'd1);
      chk("ld_nobyp", reg_rdata1, RV);
      step();
    end
    dmem_read_valid = 1'b1;
    #1;
    chk("ld_byp", reg_rdata1, 32'hFFFF_FF80);
    step();
    idle_in();
    #1;
    chk("ld_stall_end", {31'h0, stall_read}, 32'd0);
    chk("ld_store", reg_rdata1, 32'hFFFF_FF80);
    chk("ld_cnt", commit_count, 32'd2);

    // LHU offset 2, data valid in the first cycle
    load(5'd7, F3_LHU, 2'd2, 32'h8001_7FFE);
    #1;
    chk("lhu_nostall", {31'h0, stall_read}, 32'd0);
    chk("lhu_byp", reg_rdata1, 32'h0000_8001);
    step();
    idle_in();
    #1;
    chk("lhu_store", reg_rdata1, 32'h0000_8001);

    load(5'd8, F3_LH, 2'd0, 32'h8001_7FFE);
    step();
    idle_in();
    #1;
    chk("lh_store", reg_rdata1, 32'h0000_7FFE);

    load(5'd9, F3_LBU, 2'd1, 32'h80AA_BBCC);
    step();
    load(5'd10, F3_LW, 2'd0, 32'h80AA_BBCC);
    src2_select = 5'd9;
    step();
    idle_in();
    #1;
    chk("lbu_store", reg_rdata2, 32'h0000_00BB);
    chk("lw_store", reg_rdata1, 32'h80AA_BBCC);
    chk("ld_cnt2", commit_count, 32'd6);

    // valid while not a load is ignored
    dmem_read_valid = 1'b1;
    dmem_read_data  = 32'h1111_1111;
    step();
    idle_in();
    #1;
    chk("stray_cnt", commit_count, 32'd6);

    // fetch stall for 4 cycles
    wb_alu_to_reg    = 1'b1;
    wb_dest_reg_sel  = 5'd11;
    wb_result        = 32'hCAFE_F00D;
    inst_fetch_stall = 1'b1;
    src1_select      = 5'd11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fs_hold", reg_rdata1, RV);
      step();
    end
    chk("fs_cnt", commit_count, 32'd6);
    inst_fetch_stall = 1'b0;
    #1;
    chk("fs_byp", reg_rdata1, 32'hCAFE_F00D);
    step();
    idle_in();
    #1;
    chk("fs_store", reg_rdata1, 32'hCAFE_F00D);
    chk("fs_cnt2", commit_count, 32'd7);

    // reset while waiting on a load
    load(5'd12, F3_LW, 2'd0, 32'h5555_AAAA);
    dmem_read_valid = 1'b0;
    step();
    wb_mem_to_reg = 1'b0;
    #1;
    chk("rw_wait", {31'h0, stall_read}, 32'd1);
    wb_mem_to_reg   = 1'b1;
    dmem_read_valid = 1'b1;
    reset           = 1'b1;
    step();
    reset = 1'b0;
    idle_in();
    src2_select = 5'd5;
    #1;
    chk("rw_x12", reg_rdata1, RV);
    chk("rw_x5", reg_rdata2, RV);
    chk("rw_stall", {31'h0, stall_read}, 32'd0);
    chk("rw_cnt", commit_count, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
